write_bram: RTL and testbench
=============================

WRITE_BRAM -- requirements
Module: write_bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data word width.
REQ-002 SHALL have parameter LOG_MAX_ITERS, default 16, meaning iteration counter width.
REQ-003 SHALL have parameter LOG_MAX_WRITES_PER_ITER, default 16, meaning per-iteration write counter width.
REQ-004 SHALL have parameter LOG_MAX_ADDRESS, default 16, meaning BRAM address width.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: configure  in  1  load config; num_iters  in  LOG_MAX_ITERS; num_writes_per_iter  in  LOG_MAX_WRITES_PER_ITER; base_address  in  LOG_MAX_ADDRESS.
REQ-007 SHALL have upstream ports: valid_in  in  1; data_in  in  DATA_WIDTH; avail_out  out  1  space available to upstream.
REQ-008 SHALL have BRAM ports: write_out  out  1  write enable; address_out  out  LOG_MAX_ADDRESS; data_out  out  DATA_WIDTH.
REQ-009 SHALL have status ports: done  out  1  one-cycle completion pulse; overflow  out  1  sticky drop flag.

Function
REQ-010 SHALL buffer input in a 4-slot FIFO; valid_in=1 with FIFO not full pushes data_in at that clock edge.
REQ-011 SHALL drop data_in when valid_in=1 and FIFO full, and set overflow=1 until reset or configure.
REQ-012 SHALL drive avail_out = enabled & ~almost_full (occupancy <= 2), registered-free, to cover two cycles of upstream latency.
REQ-013 SHALL implement FSM states IDLE, WRITE, DONE; IDLE->WRITE on configure with nonzero num_iters and num_writes_per_iter; WRITE->DONE on last write; DONE->IDLE unconditionally.
REQ-014 SHALL go IDLE->DONE on configure with num_iters=0 or num_writes_per_iter=0 (no writes performed).
REQ-015 SHALL assert write_out combinationally when state=WRITE and FIFO not empty, with data_out=FIFO head and address_out=current address, popping the FIFO that cycle.
REQ-016 SHALL give one-cycle minimum latency: word pushed at edge t appears on write_out in cycle t+1.
REQ-017 SHALL on each write: if writes_left>1, decrement writes_left and increment address modulo 2^LOG_MAX_ADDRESS.
REQ-018 SHALL on write with writes_left=1 and iters_left>1: decrement iters_left, reload writes_left and address from configured copies.
REQ-019 SHALL on write with writes_left=1 and iters_left=1: enter DONE and assert done for exactly one cycle.
REQ-020 SHALL keep data in FIFO when IDLE/DONE; it is written after the next configure.
REQ-021 SHALL on configure during WRITE: the write of that cycle still occurs at the old address but is not counted; counters, address, overflow reload from new config.
REQ-022 SHALL hold write_out=0 in IDLE and DONE.

Reset
REQ-023 SHALL on rst=0 at a clock edge: state IDLE, FIFO empty, counters and address 0, overflow=0, done=0, write_out=0, avail_out=0.
REQ-024 SHALL treat reset mid-operation as abort: buffered data discarded, no done pulse.

Configuration
REQ-025 SHALL, with macro WRITE_BRAM_DEBUG_EN defined, keep a 16-bit cycle counter and print cycle on configure, and cycle/address/data on each write and each drop.
REQ-026 SHALL, without WRITE_BRAM_DEBUG_EN, contain no counter and no print statements; functional behaviour identical.

Structure
REQ-027 SHALL place FSM state encodings (IDLE=0, WRITE=1, DONE=2) and FIFO depth constant (4, log 2) in shared package write_bram_pkg.
REQ-028 SHALL instantiate the team's existing FIFO module (NUM_SLOTS=4) as its single sub-module.

Verification
REQ-029 SHALL cover: iters=1, writes=4, base=0x10, data 0xA1..0xA4 back-to-back -> writes at 0x10..0x13, done one cycle after last write.
REQ-030 SHALL cover: iters=3, writes=2, base=0x20 -> six writes at 0x20,0x21,0x20,0x21,0x20,0x21, single done pulse.
REQ-031 SHALL cover: base=0xFFFF, writes=3 -> addresses 0xFFFF,0x0000,0x0001.
REQ-032 SHALL cover: module unconfigured, valid_in for 5 cycles -> 4 words buffered, 5th dropped, overflow=1, avail_out=0 throughout.
REQ-033 SHALL cover: configure with num_iters=0 -> done pulses next cycle, write_out never asserted.
REQ-034 SHALL cover: rst=0 after 2 of 4 writes -> all outputs reset values next cycle, no done, FIFO empty.

Source files
------------

// File: rtl/write_bram_pkg.sv
// write_bram_pkg: FSM state encodings and FIFO sizing shared by write_bram and its FIFO.
package write_bram_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_LOG = 2;
endpackage

// File: rtl/write_bram_fifo.sv
// write_bram_fifo: small synchronous FIFO with combinational head and occupancy count.
module write_bram_fifo #(
   parameter int WIDTH = 8,
   parameter int NUM_SLOTS = 4,
   parameter int LOG_SLOTS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     data_in,
   output logic [WIDTH-1:0]     head,
   output logic                 empty,
   output logic                 full,
   output logic [LOG_SLOTS:0]   count
);
   logic [WIDTH-1:0] mem [NUM_SLOTS];
   logic [LOG_SLOTS-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (LOG_SLOTS+1)'(NUM_SLOTS);
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= data_in;
   always_ff @(posedge clk)
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + LOG_SLOTS'(1);
         if (do_pop) rd_ptr <= rd_ptr + LOG_SLOTS'(1);
         count <= count + (LOG_SLOTS+1)'(do_push) - (LOG_SLOTS+1)'(do_pop);
      end
endmodule

// File: rtl/write_bram.sv
// write_bram: streams buffered words into BRAM over num_iters passes of num_writes_per_iter addresses.
// Define WRITE_BRAM_DEBUG_EN for a cycle counter and trace prints of configures, writes and drops.
module write_bram
   import write_bram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LOG_MAX_ITERS = 16,
   parameter int LOG_MAX_WRITES_PER_ITER = 16,
   parameter int LOG_MAX_ADDRESS = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               configure,
   input  logic [LOG_MAX_ITERS-1:0]           num_iters,
   input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
   input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
   input  logic                               valid_in,
   input  logic [DATA_WIDTH-1:0]              data_in,
   output logic                               avail_out,
   output logic                               write_out,
   output logic [LOG_MAX_ADDRESS-1:0]         address_out,
   output logic [DATA_WIDTH-1:0]              data_out,
   output logic                               done,
   output logic                               overflow
);
   state_t state, state_next;
   logic [LOG_MAX_ITERS-1:0] iters_left;
   logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_left, cfg_writes;
   logic [LOG_MAX_ADDRESS-1:0] address, cfg_base;
   logic [FIFO_LOG:0] count;
   logic empty, full, start, last;
   write_bram_fifo #(.WIDTH(DATA_WIDTH), .NUM_SLOTS(FIFO_DEPTH), .LOG_SLOTS(FIFO_LOG)) fifo (
      .clk(clk),
      .rst(rst),
      .push(valid_in),
      .pop(write_out),
      .data_in(data_in),
      .head(data_out),
      .empty(empty),
      .full(full),
      .count(count)
   );
   assign write_out = (state == WRITE) & ~empty;
   assign address_out = address;
   assign done = state == DONE;
   // Leaves two free slots for words already in flight from upstream.
   assign avail_out = (state == WRITE) & (count <= (FIFO_LOG+1)'(2));
   assign start = configure & (num_iters != '0) & (num_writes_per_iter != '0);
   assign last = write_out & (writes_left == LOG_MAX_WRITES_PER_ITER'(1)) & (iters_left == LOG_MAX_ITERS'(1));
   always_comb begin
      state_next = state;
      state_next = configure ? (start ? WRITE : DONE) : last ? DONE : (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         iters_left <= '0;
         writes_left <= '0;
         cfg_writes <= '0;
         address <= '0;
         cfg_base <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         overflow <= configure ? 1'b0 : overflow | (valid_in & full);
         // A write coinciding with configure lands at the old address but is not counted.
         if (configure) begin
            iters_left <= num_iters;
            writes_left <= num_writes_per_iter;
            cfg_writes <= num_writes_per_iter;
            address <= base_address;
            cfg_base <= base_address;
         end else if (write_out) begin
            if (writes_left > LOG_MAX_WRITES_PER_ITER'(1)) begin
               writes_left <= writes_left - LOG_MAX_WRITES_PER_ITER'(1);
               address <= address + LOG_MAX_ADDRESS'(1);
            end else if (iters_left > LOG_MAX_ITERS'(1)) begin
               iters_left <= iters_left - LOG_MAX_ITERS'(1);
               writes_left <= cfg_writes;
               address <= cfg_base;
            end else begin
               iters_left <= '0;
               writes_left <= '0;
            end
         end
      end
`ifdef WRITE_BRAM_DEBUG_EN
   logic [15:0] cycle;
   always_ff @(posedge clk) begin
      cycle <= !rst ? 16'd0 : cycle + 16'd1;
      if (rst && configure) $display("write_bram: cycle %0d configure", cycle);
      if (rst && write_out) $display("write_bram: cycle %0d write addr %0h data %0h", cycle, address_out, data_out);
      if (rst && valid_in && full) $display("write_bram: cycle %0d drop addr %0h data %0h", cycle, address_out, data_in);
   end
`endif
endmodule

// File: tb/tb_write_bram.sv
// tb_write_bram: directed vectors for write_bram with a logged view of every observed write and done pulse.
module tb_write_bram;
   logic clk, rst, configure, valid_in, avail_out, write_out, done, overflow;
   logic [15:0] num_iters, num_writes_per_iter, base_address, address_out;
   logic [7:0] data_in, data_out;
   int checks, errors, cyc;
   logic [15:0] wa[$], ea[$];
   logic [7:0] wd[$], ed[$];
   int wc[$], dc[$];
   write_bram dut (
      .clk(clk),
      .rst(rst),
      .configure(configure),
      .num_iters(num_iters),
      .num_writes_per_iter(num_writes_per_iter),
      .base_address(base_address),
      .valid_in(valid_in),
      .data_in(data_in),
      .avail_out(avail_out),
      .write_out(write_out),
      .address_out(address_out),
      .data_out(data_out),
      .done(done),
      .overflow(overflow)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (write_out) begin
         wa.push_back(address_out);
         wd.push_back(data_out);
         wc.push_back(cyc);
      end
      if (done) dc.push_back(cyc);
   endtask
   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); dc.delete(); ea.delete(); ed.delete();
   endtask
   task automatic exp_w(input logic [15:0] a, input logic [7:0] d);
      ea.push_back(a);
      ed.push_back(d);
   endtask
   task automatic check_log(input string tag, input int ndone);
      check({tag, "_nwrites"}, 32'(wa.size()), 32'(ea.size()));
      foreach (ea[i]) begin
         check({tag, "_addr"}, 32'(i < wa.size() ? wa[i] : 16'hxxxx), 32'(ea[i]));
         check({tag, "_data"}, 32'(i < wd.size() ? wd[i] : 8'hxx), 32'(ed[i]));
      end
      check({tag, "_ndone"}, 32'(dc.size()), 32'(ndone));
      if (dc.size() > 0 && wc.size() > 0) check({tag, "_done_cycle"}, 32'(dc[0]), 32'(wc[wc.size()-1] + 1));
      clear_log();
   endtask
   task automatic cfg(input logic [15:0] it, input logic [15:0] wr, input logic [15:0] base);
      configure = 1'b1;
      num_iters = it;
      num_writes_per_iter = wr;
      base_address = base;
   endtask
   initial begin
      checks = 0; errors = 0; cyc = 0;
      rst = 1'b0; configure = 1'b0; valid_in = 1'b0; data_in = '0;
      num_iters = '0; num_writes_per_iter = '0; base_address = '0;
      tick(); tick();
      check("rst_write", 32'(write_out), 0);
      check("rst_avail", 32'(avail_out), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_addr", 32'(address_out), 0);
      rst = 1'b1;
      // unconfigured: four words buffered, fifth dropped
      for (int i = 0; i < 5; i++) begin
         valid_in = 1'b1;
         data_in = 8'(8'h51 + i);
         tick();
         check("unc_avail", 32'(avail_out), 0);
      end
      check("unc_overflow", 32'(overflow), 1);
      check("unc_write", 32'(write_out), 0);
      valid_in = 1'b0;
      clear_log();
      cfg(16'd1, 16'd4, 16'h0040);
      tick();
      configure = 1'b0;
      check("cfg_overflow_clr", 32'(overflow), 0);
      check("full_avail", 32'(avail_out), 0);
      for (int i = 0; i < 6; i++) tick();
      for (int i = 0; i < 4; i++) exp_w(16'(16'h40 + i), 8'(8'h51 + i));
      check_log("drain", 1);
      // one pass of four back-to-back words
      cfg(16'd1, 16'd4, 16'h0010);
      valid_in = 1'b1;
      data_in = 8'hA1;
      tick();
      configure = 1'b0;
      check("run_avail", 32'(avail_out), 1);
      for (int i = 1; i < 4; i++) begin
         data_in = 8'(8'hA1 + i);
         tick();
      end
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 4; i++) exp_w(16'(16'h10 + i), 8'(8'hA1 + i));
      check_log("single", 1);
      check("idle_after_done", 32'(done), 0);
      // three passes of two writes
      cfg(16'd3, 16'd2, 16'h0020);
      valid_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_in = 8'(8'hC1 + i);
         tick();
         configure = 1'b0;
      end
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 6; i++) exp_w(16'(16'h20 + (i % 2)), 8'(8'hC1 + i));
      check_log("iters", 1);
      // address wraps past the top of the space
      cfg(16'd1, 16'd3, 16'hFFFF);
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'(8'hD1 + i);
         tick();
         configure = 1'b0;
      end
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      exp_w(16'hFFFF, 8'hD1);
      exp_w(16'h0000, 8'hD2);
      exp_w(16'h0001, 8'hD3);
      check_log("wrap", 1);
      // zero iterations: immediate done, buffered word stays
      valid_in = 1'b1;
      data_in = 8'hE1;
      tick();
      valid_in = 1'b0;
      cfg(16'd0, 16'd5, 16'h0060);
      tick();
      configure = 1'b0;
      check("zero_done", 32'(done), 1);
      tick(); tick();
      check_log("zero", 1);
      // reset after two observed writes aborts everything
      cfg(16'd1, 16'd4, 16'h0030);
      valid_in = 1'b1;
      data_in = 8'hF1;
      tick();
      configure = 1'b0;
      data_in = 8'hF2;
      tick();
      rst = 1'b0;
      valid_in = 1'b0;
      tick();
      check("abort_write", 32'(write_out), 0);
      check("abort_done", 32'(done), 0);
      check("abort_avail", 32'(avail_out), 0);
      check("abort_overflow", 32'(overflow), 0);
      check("abort_addr", 32'(address_out), 0);
      tick();
      rst = 1'b1;
      exp_w(16'h0030, 8'hE1);
      exp_w(16'h0031, 8'hF1);
      check_log("abort", 0);
      cfg(16'd1, 16'd1, 16'h0050);
      tick();
      configure = 1'b0;
      tick(); tick();
      check("abort_fifo_empty", 32'(write_out), 0);
      valid_in = 1'b1;
      data_in = 8'h77;
      tick();
      valid_in = 1'b0;
      tick(); tick();
      exp_w(16'h0050, 8'h77);
      check_log("post_abort", 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
